// File: rtl/parallel_host.sv
// Initiator for the 8-bit parallel accelerometer-readout bus: sends one axis command, then reads back a 16-bit sample.
// Optional autopoll (x->y->z round robin while idle) is compiled in with `define PARALLEL_HOST_AUTOPOLL_EN.
module parallel_host #(
    parameter int CLK_DIV = 4
) (
    input  logic        CLK_50,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_axis,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_axis,
    output logic        req_err,
    output logic        busy,
    output logic        BUS_CLK,
    output logic        BUS_CS,
    inout  wire  [7:0]  BUS_DATA,
    input  logic        poll_en
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, SETUP, CMD_HI, TURN, E2_HI, E2_LO, E3_HI, E3_LO, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    axis;
    logic [7:0]    cmd_byte;
    logic [7:0]    lo_byte;
    logic          start_req;
    logic [1:0]    start_axis;

`ifdef PARALLEL_HOST_AUTOPOLL_EN
    logic [1:0] poll_ptr;
    logic       from_poll;

    // An external request always wins over the self-issued one.
    always_comb begin
        start_req  = req_valid | poll_en;
        start_axis = req_valid ? req_axis : poll_ptr;
        from_poll  = ~req_valid & poll_en;
    end
`else
    logic unused_poll_en;
    assign unused_poll_en = poll_en;

    always_comb begin
        start_req  = req_valid;
        start_axis = req_axis;
    end
`endif

    assign req_ready = (state == IDLE) && !RST;
    assign busy      = (state != IDLE);
    // The host only drives the data bus while it owns it (CS high).
    assign BUS_DATA  = BUS_CS ? cmd_byte : 8'hzz;

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            state     <= IDLE;
            count     <= '0;
            axis      <= '0;
            cmd_byte  <= '0;
            lo_byte   <= '0;
            BUS_CLK   <= 1'b0;
            BUS_CS    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_axis  <= '0;
            req_err   <= 1'b0;
`ifdef PARALLEL_HOST_AUTOPOLL_EN
            poll_ptr  <= 2'd0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            req_err   <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (start_req) begin
                        if (start_axis == 2'd3) begin
                            req_err <= 1'b1;
                        end else begin
                            axis     <= start_axis;
                            cmd_byte <= 8'd120 + {6'd0, start_axis};
                            BUS_CS   <= 1'b1;
                            BUS_CLK  <= 1'b0;
                            state    <= SETUP;
                        end
`ifdef PARALLEL_HOST_AUTOPOLL_EN
                        if (from_poll) begin
                            poll_ptr <= (poll_ptr == 2'd2) ? 2'd0 : poll_ptr + 2'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    if (count != LAST) begin
                        count <= count + CW'(1);
                    end else begin
                        count <= '0;
                        // Each timed phase ends here; BUS_CLK/BUS_CS for the next phase are registered now.
                        case (state)
                            SETUP: begin
                                state   <= CMD_HI;
                                BUS_CLK <= 1'b1;
                            end
                            CMD_HI: begin
                                state   <= TURN;
                                BUS_CLK <= 1'b0;
                                BUS_CS  <= 1'b0;
                            end
                            TURN: begin
                                state   <= E2_HI;
                                BUS_CLK <= 1'b1;
                            end
                            E2_HI: begin
                                state   <= E2_LO;
                                BUS_CLK <= 1'b0;
                            end
                            E2_LO: begin
                                state   <= E3_HI;
                                lo_byte <= BUS_DATA;
                                BUS_CLK <= 1'b1;
                            end
                            E3_HI: begin
                                state   <= E3_LO;
                                BUS_CLK <= 1'b0;
                            end
                            E3_LO: begin
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_data  <= {BUS_DATA, lo_byte};
                                rsp_axis  <= axis;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_parallel_host.sv
// Bench for parallel_host: responder model on the shared bus, vector table, hand-written corner sequences and random traffic.
// Autopoll sequences run only when PARALLEL_HOST_AUTOPOLL_EN is defined.
module tb_parallel_host;
    localparam int CLK_DIV = 4;
    localparam int LAT     = 7 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_axis;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_axis;
    logic        req_err;
    logic        busy;
    logic        bus_clk;
    logic        bus_cs;
    wire  [7:0]  bus_data;
    logic        poll_en;

    int checks = 0;
    int errors = 0;

    logic        resp_oe = 1'b0;
    logic [7:0]  resp_byte = 8'h00;
    logic [7:0]  resp_cmd = 8'h00;
    logic [15:0] resp_value = 16'h0000;
    logic [15:0] resp_cur = 16'h0000;
    int          resp_edges = 0;
    logic        resp_prev_clk = 1'b0;
    logic        contention_seen = 1'b0;

    assign bus_data = resp_oe ? resp_byte : 8'hzz;

    parallel_host #(.CLK_DIV(CLK_DIV)) dut (
        .CLK_50(clk), .RST(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_axis(req_axis), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_axis(rsp_axis), .req_err(req_err), .busy(busy), .BUS_CLK(bus_clk),
        .BUS_CS(bus_cs), .BUS_DATA(bus_data), .poll_en(poll_en)
    );

    always #5 clk = ~clk;

    // Responder: latch the command on rising edge 1, drive low byte from edge 2, high byte from edge 3.
    always @(negedge clk) begin
        if (rst || !busy) begin
            resp_oe    = 1'b0;
            resp_edges = 0;
            resp_cmd   = 8'h00;
        end else if (bus_clk && !resp_prev_clk) begin
            resp_edges = resp_edges + 1;
            if (resp_edges == 1) begin
                resp_cmd = bus_data;
                resp_cur = resp_value;
            end else if (resp_edges == 2) begin
                resp_byte = resp_cur[7:0];
                resp_oe   = 1'b1;
            end else if (resp_edges == 3) begin
                resp_byte = resp_cur[15:8];
            end
        end
        resp_prev_clk = bus_clk;
        if (resp_oe && bus_cs) contention_seen = 1'b1;
    end

    typedef struct {
        logic [1:0]  axis;
        logic [15:0] sample;
        logic        exp_err;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic exp_cs(input int n);
        return (n >= 1) && (n <= 2 * CLK_DIV);
    endfunction

    // Phases of CLK_DIV cycles: SETUP, CMD_HI, TURN, E2_HI, E2_LO, E3_HI, E3_LO; the odd ones hold BUS_CLK high.
    function automatic logic exp_clk(input int n);
        return (n >= 1) && (n <= 7 * CLK_DIV) && ((((n - 1) / CLK_DIV) % 2) == 1);
    endfunction

    task automatic apply_stimulus(input string tag, input logic [1:0] axis, input logic [15:0] sample,
                                  input logic exp_err, input logic [7:0] exp_cmd, input logic [15:0] exp_data);
        int rises = 0, rsp_cnt = 0, rsp_at = -1, err_cnt = 0, err_at = -1, shape_bad = 0;
        logic prev_clk;
        logic [15:0] got_data = '0;
        logic [1:0]  got_axis = '0;
        logic [7:0]  got_cmd = '0;
        resp_value = sample;
        @(negedge clk);
        check_output({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_axis  = axis;
        prev_clk  = bus_clk;
        for (int n = 1; n <= LAT + 4; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (bus_clk && !prev_clk) rises++;
            prev_clk = bus_clk;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_at   = n;
                got_data = rsp_data;
                got_axis = rsp_axis;
                got_cmd  = resp_cmd;
            end
            if (req_err) begin
                err_cnt++;
                err_at = n;
            end
            if (exp_err) begin
                if (bus_cs || bus_clk || busy) shape_bad++;
            end else if (bus_cs !== exp_cs(n) || bus_clk !== exp_clk(n) || busy !== (n <= LAT)) begin
                shape_bad++;
            end
        end
        check_output({tag, "_bus_shape"}, 32'(shape_bad), 32'd0);
        check_output({tag, "_contention"}, 32'(contention_seen), 32'd0);
        if (exp_err) begin
            check_output({tag, "_err_count"}, 32'(err_cnt), 32'd1);
            check_output({tag, "_err_cycle"}, 32'(err_at), 32'd1);
            check_output({tag, "_clk_rises"}, 32'(rises), 32'd0);
            check_output({tag, "_rsp_count"}, 32'(rsp_cnt), 32'd0);
            check_output({tag, "_data_held"}, 32'(rsp_data), 32'(exp_data));
        end else begin
            check_output({tag, "_err_count"}, 32'(err_cnt), 32'd0);
            check_output({tag, "_clk_rises"}, 32'(rises), 32'd3);
            check_output({tag, "_rsp_count"}, 32'(rsp_cnt), 32'd1);
            check_output({tag, "_latency"}, 32'(rsp_at), 32'(LAT));
            check_output({tag, "_cmd"}, 32'(got_cmd), 32'(exp_cmd));
            check_output({tag, "_rsp_data"}, 32'(got_data), 32'(exp_data));
            check_output({tag, "_rsp_axis"}, 32'(got_axis), 32'(axis));
            check_output({tag, "_data_held"}, 32'(rsp_data), 32'(exp_data));
        end
    endtask

    task automatic run_held();
        int rsp_cnt = 0, ready_bad = 0;
        int at[2];
        logic [1:0]  ax[2];
        logic [15:0] dt[2];
        at = '{-1, -1};
        ax = '{2'd3, 2'd3};
        dt = '{16'h0, 16'h0};
        resp_value = 16'h1111;
        @(negedge clk);
        req_valid = 1'b1;
        req_axis  = 2'd0;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (n == 10) req_axis = 2'd1;
            if (n == 15) resp_value = 16'h2222;
            if (n <= LAT && req_ready) ready_bad++;
            if (n == LAT + 1) check_output("held_ready_after_done", 32'(req_ready), 32'd1);
            if (rsp_valid) begin
                if (rsp_cnt < 2) begin
                    at[rsp_cnt] = n;
                    ax[rsp_cnt] = rsp_axis;
                    dt[rsp_cnt] = rsp_data;
                end
                rsp_cnt++;
                if (rsp_cnt >= 2) req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check_output("held_ready_while_busy", 32'(ready_bad), 32'd0);
        check_output("held_rsp_count", 32'(rsp_cnt), 32'd2);
        check_output("held_first_at", 32'(at[0]), 32'(LAT));
        check_output("held_first_axis", 32'(ax[0]), 32'd0);
        check_output("held_first_data", 32'(dt[0]), 32'h1111);
        check_output("held_second_at", 32'(at[1]), 32'(2 * LAT + 1));
        check_output("held_second_axis", 32'(ax[1]), 32'd1);
        check_output("held_second_data", 32'(dt[1]), 32'h2222);
    endtask

    task automatic run_reset_mid();
        int stray = 0;
        resp_value = 16'hABCD;
        @(negedge clk);
        req_valid = 1'b1;
        req_axis  = 2'd0;
        for (int n = 1; n <= 3 * CLK_DIV + 1; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
        end
        check_output("rstmid_e2hi_clk", 32'(bus_clk), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_output("rstmid_bus_clk", 32'(bus_clk), 32'd0);
        check_output("rstmid_bus_cs", 32'(bus_cs), 32'd0);
        check_output("rstmid_busy", 32'(busy), 32'd0);
        check_output("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rstmid_req_ready", 32'(req_ready), 32'd0);
        check_output("rstmid_rsp_data", 32'(rsp_data), 32'd0);
        check_output("rstmid_rsp_axis", 32'(rsp_axis), 32'd0);
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_valid || busy) stray++;
        end
        check_output("rstmid_no_stray_rsp", 32'(stray), 32'd0);
    endtask

`ifdef PARALLEL_HOST_AUTOPOLL_EN
    task automatic wait_rsp(output logic [1:0] ax, output logic ok);
        ok = 1'b0;
        ax = 2'd3;
        for (int i = 0; i < 3 * LAT && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                ax = rsp_axis;
            end
        end
    endtask

    task automatic run_autopoll();
        logic [1:0] ax;
        logic ok;
        logic [1:0] seq1[4];
        logic [1:0] seq2[5];
        seq1 = '{2'd0, 2'd1, 2'd2, 2'd0};
        seq2 = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        poll_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(ax, ok);
            check_output($sformatf("poll_seq1_got_%0d", i), 32'(ok), 32'd1);
            check_output($sformatf("poll_seq1_axis_%0d", i), 32'(ax), 32'(seq1[i]));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(ax, ok);
            check_output($sformatf("poll_seq2_got_%0d", i), 32'(ok), 32'd1);
            check_output($sformatf("poll_seq2_axis_%0d", i), 32'(ax), 32'(seq2[i]));
            if (i == 0) begin
                req_valid = 1'b1;
                req_axis  = 2'd2;
                @(negedge clk);
                @(negedge clk);
                req_valid = 1'b0;
            end
        end
        poll_en = 1'b0;
        for (int i = 0; i < 2 * LAT && busy; i++) @(negedge clk);
        check_output("poll_stops", 32'(busy), 32'd0);
    endtask
`else
    task automatic run_poll_ignored();
        int active = 0;
        poll_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || rsp_valid || bus_cs) active++;
        end
        poll_en = 1'b0;
        check_output("poll_ignored", 32'(active), 32'd0);
    endtask
`endif

    initial begin
        logic [15:0] last_data;
        logic [1:0]  r_axis;
        logic [15:0] r_sample;
        logic        r_err;

        rst = 1'b1;
        req_valid = 1'b0;
        req_axis = 2'd0;
        poll_en = 1'b0;

        vecs[0] = '{2'd0, 16'h3412, 1'b0, 8'h78, 16'h3412};
        vecs[1] = '{2'd2, 16'hBEEF, 1'b0, 8'h7A, 16'hBEEF};
        vecs[2] = '{2'd3, 16'h5555, 1'b1, 8'h00, 16'hBEEF};
        vecs[3] = '{2'd1, 16'h0079, 1'b0, 8'h79, 16'h0079};
        vecs[4] = '{2'd1, 16'hFFFF, 1'b0, 8'h79, 16'hFFFF};
        vecs[5] = '{2'd0, 16'h0000, 1'b0, 8'h78, 16'h0000};

        repeat (3) @(negedge clk);
        check_output("reset_bus_clk", 32'(bus_clk), 32'd0);
        check_output("reset_bus_cs", 32'(bus_cs), 32'd0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rsp_data", 32'(rsp_data), 32'd0);
        check_output("reset_rsp_axis", 32'(rsp_axis), 32'd0);
        check_output("reset_req_err", 32'(req_err), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].axis, vecs[i].sample,
                           vecs[i].exp_err, vecs[i].exp_cmd, vecs[i].exp_data);
        end

        run_held();
        last_data = 16'h2222;

        for (int i = 0; i < 10; i++) begin
            r_axis   = 2'($urandom_range(0, 3));
            r_sample = 16'($urandom);
            r_err    = (r_axis == 2'd3);
            if (!r_err) last_data = r_sample;
            apply_stimulus($sformatf("rnd%0d", i), r_axis, r_sample, r_err,
                           8'(120 + int'(r_axis)), last_data);
        end

        run_reset_mid();
        apply_stimulus("rst_then_y", 2'd1, 16'h0079, 1'b0, 8'h79, 16'h0079);

`ifdef PARALLEL_HOST_AUTOPOLL_EN
        run_autopoll();
`else
        run_poll_ignored();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
